flash_programmer: RTL

- SPI NOR flash writer; the programming counterpart of the boot-time flash loader. It writes RAM images into the same serial flash that the loader later reads back.
- Takes a start address and a word count, then accepts 32-bit words over a valid/ready stream.
- Issues optional Bulk Erase, then Write Enable + Page Program per 256-byte page, polling Read Status until Write In Progress (WIP) clears.
- Sits on the flash pins (muxed against the loader after boot) and is driven by a debug/UART host stream.

---
 rtl/flash_programmer_if.sv | 36 +++
 rtl/flash_programmer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/flash_programmer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// flash_programmer_if : host word stream plus SPI NOR flash pin bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
interface flash_programmer_if #(
  parameter int unsigned WORDS_W = 16
);
  logic               start;
  logic               erase_en;
  logic [23:0]        start_addr;
  logic [WORDS_W-1:0] num_words;
  logic [31:0]        wr_data;
  logic               wr_valid;
  logic               wr_ready;
  logic               busy;
  logic               done;
  logic               error;
  logic               flash_cs;
  logic               flash_sck;
  logic               flash_si;
  logic               flash_so_io1;
  logic               flash_wp_n;
  logic               flash_hold_n;

  modport master (
    output start, erase_en, start_addr, num_words, wr_data, wr_valid, flash_so_io1,
    input  wr_ready, busy, done, error, flash_cs, flash_sck, flash_si, flash_wp_n, flash_hold_n
  );

  modport slave (
    input  start, erase_en, start_addr, num_words, wr_data, wr_valid, flash_so_io1,
    output wr_ready, busy, done, error, flash_cs, flash_sck, flash_si, flash_wp_n, flash_hold_n
  );
endinterface
`default_nettype wire

// File: rtl/flash_programmer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// flash_programmer : SPI NOR writer (optional bulk erase, WREN+PP per page, WIP poll)
// Revision: 1.0
// ---------------------------------------------------------------------------
module flash_programmer #(
  parameter int unsigned CS_GAP   = 4,
  parameter logic [23:0] POLL_MAX = 24'hFF_FFFF,
  parameter int unsigned WORDS_W  = 16
) (
  input wire logic          sys_clk,
  input wire logic          sys_rst,
  flash_programmer_if.slave bus
);
  localparam int unsigned GAP_W = $clog2(CS_GAP + 1);
  localparam logic [GAP_W-1:0]   c_GAP_LOAD = GAP_W'(CS_GAP - 1);
  localparam logic [GAP_W-1:0]   c_GAP_ONE  = GAP_W'(1);
  localparam logic [WORDS_W-1:0] c_WORD_ONE = WORDS_W'(1);
  localparam logic [7:0] c_OP_WREN = 8'h06;
  localparam logic [7:0] c_OP_BE   = 8'h60;
  localparam logic [7:0] c_OP_PP   = 8'h02;
  localparam logic [7:0] c_OP_RDSR = 8'h05;

  typedef enum logic [3:0] {
    S_IDLE, S_WREN, S_GAP, S_ERASE, S_POLL, S_PP_HDR, S_PP_LOAD, S_PP_DATA, S_DONE
  } state_t;

  state_t             state_q, state_d, next_q, next_d;
  logic               erase_pend_q, erase_pend_d;
  logic [23:0]        addr_q, addr_d;
  logic [WORDS_W-1:0] words_left_q, words_left_d;
  logic [23:0]        poll_cnt_q, poll_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [5:0]         bit_cnt_q, bit_cnt_d;
  logic [39:0]        sr_q, sr_d;
  logic               cs_q, cs_d;
  logic               clk_en_q, clk_en_d;
  logic               error_q, error_d;
  logic               launch;
  state_t             launch_st;
  logic [23:0]        w_start_addr, w_addr_inc, w_poll_inc;
  logic [WORDS_W-1:0] w_words_dec;

  function automatic logic [39:0] cmd_sr(input state_t s, input logic [23:0] a);
    case (s)
      S_ERASE:  cmd_sr = {c_OP_BE, 32'h0};
      S_POLL:   cmd_sr = {c_OP_RDSR, 32'h0};
      S_PP_HDR: cmd_sr = {c_OP_PP, a, 8'h00};
      default:  cmd_sr = {c_OP_WREN, 32'h0};
    endcase
  endfunction

  // Bits remaining after the first one; RDSR covers opcode plus status byte.
  function automatic logic [5:0] cmd_bits(input state_t s);
    case (s)
      S_POLL:   cmd_bits = 6'd15;
      S_PP_HDR: cmd_bits = 6'd31;
      default:  cmd_bits = 6'd7;
    endcase
  endfunction

  assign w_start_addr = bus.start_addr & 24'hFF_FFFC;
  assign w_addr_inc   = addr_q + 24'd4;
  assign w_poll_inc   = poll_cnt_q + 24'd1;
  assign w_words_dec  = words_left_q - c_WORD_ONE;

  always_comb begin
    state_d      = state_q;
    next_d       = next_q;
    erase_pend_d = erase_pend_q;
    addr_d       = addr_q;
    words_left_d = words_left_q;
    poll_cnt_d   = poll_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    sr_d         = sr_q;
    cs_d         = cs_q;
    clk_en_d     = clk_en_q;
    error_d      = error_q;
    launch       = 1'b0;
    launch_st    = S_WREN;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          addr_d       = w_start_addr;
          words_left_d = bus.num_words;
          poll_cnt_d   = '0;
          error_d      = 1'b0;
          erase_pend_d = bus.erase_en;
          if (bus.erase_en || (bus.num_words != '0)) launch = 1'b1;
          else state_d = S_DONE;
        end
      end
      S_WREN, S_ERASE: begin
        sr_d      = sr_q << 1;
        bit_cnt_d = bit_cnt_q - 6'd1;
        if (bit_cnt_q == 6'd0) begin
          cs_d      = 1'b1;
          clk_en_d  = 1'b0;
          state_d   = S_GAP;
          gap_cnt_d = c_GAP_LOAD;
          if (state_q == S_ERASE) begin
            next_d       = S_POLL;
            erase_pend_d = 1'b0;
          end else begin
            next_d = erase_pend_q ? S_ERASE : S_PP_HDR;
          end
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q - c_GAP_ONE;
        if (gap_cnt_q == '0) begin
          if (next_q == S_DONE) state_d = S_DONE;
          else begin
            launch    = 1'b1;
            launch_st = next_q;
          end
        end
      end
      S_POLL: begin
        sr_d      = sr_q << 1;
        bit_cnt_d = bit_cnt_q - 6'd1;
        if (bit_cnt_q == 6'd0) begin
          // The final sampled bit is status[0] (WIP). Completion also passes
          // through GAP so a back-to-back job still honours the CS high time.
          cs_d       = 1'b1;
          clk_en_d   = 1'b0;
          state_d    = S_GAP;
          gap_cnt_d  = c_GAP_LOAD;
          poll_cnt_d = w_poll_inc;
          if (bus.flash_so_io1) begin
            if (w_poll_inc >= POLL_MAX) begin
              error_d = 1'b1;
              next_d  = S_DONE;
            end else begin
              next_d = S_POLL;
            end
          end else begin
            poll_cnt_d = '0;
            next_d     = (words_left_q == '0) ? S_DONE : S_WREN;
          end
        end
      end
      S_PP_HDR: begin
        sr_d      = sr_q << 1;
        bit_cnt_d = bit_cnt_q - 6'd1;
        if (bit_cnt_q == 6'd0) begin
          clk_en_d = 1'b0;
          state_d  = S_PP_LOAD;
        end
      end
      S_PP_LOAD: begin
        if (bus.wr_valid) begin
          sr_d      = {bus.wr_data, 8'h00};
          bit_cnt_d = 6'd31;
          clk_en_d  = 1'b1;
          state_d   = S_PP_DATA;
        end
      end
      S_PP_DATA: begin
        sr_d      = sr_q << 1;
        bit_cnt_d = bit_cnt_q - 6'd1;
        if (bit_cnt_q == 6'd0) begin
          addr_d       = w_addr_inc;
          words_left_d = w_words_dec;
          clk_en_d     = 1'b0;
          if ((w_words_dec == '0) || (w_addr_inc[7:0] == 8'h00)) begin
            cs_d      = 1'b1;
            state_d   = S_GAP;
            gap_cnt_d = c_GAP_LOAD;
            next_d    = S_POLL;
          end else begin
            state_d = S_PP_LOAD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      state_d   = launch_st;
      sr_d      = cmd_sr(launch_st, addr_q);
      bit_cnt_d = cmd_bits(launch_st);
      cs_d      = 1'b0;
      clk_en_d  = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      next_q       <= S_IDLE;
      erase_pend_q <= 1'b0;
      addr_q       <= '0;
      words_left_q <= '0;
      poll_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      sr_q         <= '0;
      cs_q         <= 1'b1;
      clk_en_q     <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_q       <= next_d;
      erase_pend_q <= erase_pend_d;
      addr_q       <= addr_d;
      words_left_q <= words_left_d;
      poll_cnt_q   <= poll_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      sr_q         <= sr_d;
      cs_q         <= cs_d;
      clk_en_q     <= clk_en_d;
      error_q      <= error_d;
    end
  end

  assign bus.flash_cs     = cs_q;
  assign bus.flash_sck    = clk_en_q & ~sys_clk;
  assign bus.flash_si     = sr_q[39];
  assign bus.flash_wp_n   = 1'b1;
  assign bus.flash_hold_n = 1'b1;
  assign bus.wr_ready     = (state_q == S_PP_LOAD);
  assign bus.busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.error        = error_q;
endmodule
`default_nettype wire
